// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package arm_fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; combinational head. Reset clears pointers and count only,
// so the storage array carries no reset.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  // Flush wins over both push and pop in the same cycle.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: req/ack fetch FSM feeding a small {pc, instr} FIFO,
// with redirect flushing the buffer and dropping any in-flight word.
module instr_prefetch
  import arm_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_take,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   req_addr_q, req_addr_d;

  logic          fifo_push, fifo_pop, fifo_flush;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic [63:0]   fifo_head;
  logic          ack_push, do_pop, space_left;

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({req_addr_q, imem_rdata}),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .count     (fifo_count),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign instr_valid = ~fifo_empty;
  assign do_pop      = instr_take & instr_valid;
  // Only an ack for a live (non-discarded) request, not overridden by redirect, is kept.
  assign ack_push    = (state_q == REQ) & imem_ack & ~redirect;
  assign count_next  = fifo_count + CW'(ack_push) - CW'(do_pop);
  assign space_left  = (count_next < CW'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fpc_q      <= '0;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    req_addr_d = req_addr_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          fpc_d = word_align(redirect_pc);
        end else if (fifo_count < CW'(DEPTH)) begin
          req_addr_d = fpc_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fpc_d   = word_align(redirect_pc);
          state_d = imem_ack ? IDLE : DISCARD;
        end else if (imem_ack) begin
          fpc_d = fpc_q + INSTR_BYTES;
          if (space_left) begin
            req_addr_d = fpc_q + INSTR_BYTES;
            state_d    = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        // The request address is held until memory answers; the answer is thrown away.
        if (redirect) fpc_d = word_align(redirect_pc);
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req   = (state_q != IDLE);
    imem_addr  = req_addr_q;
    fifo_push  = ack_push;
    fifo_pop   = do_pop;
    fifo_flush = redirect;
    instr      = instr_valid ? fifo_head[31:0]  : 32'h0;
    instr_pc   = instr_valid ? fifo_head[63:32] : 32'h0;
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench: randomized memory latency, take and redirect traffic against a
// queue-based reference of the fetch stream, plus directed scenarios with literal expectations.
module tb_instr_prefetch;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_take;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  instr_prefetch #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_take  (instr_take),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: buffered words, next fetch PC, and the memory's view of the outstanding request.
  logic [31:0] q_pc[$];
  logic [31:0] q_word[$];
  logic [31:0] m_fpc;
  bit          pending, stale;
  int          remaining;
  logic [31:0] pend_addr;
  bit          prev_req, prev_ack, prev_acc, prev_redirect;
  int          prev_count;

  // Stimulus knobs.
  int          lat_min, lat_max, take_pct, redir_permil;
  bit          force_redir;
  logic [31:0] force_pc;
  bit          redir_on_ack_en;
  logic [31:0] redir_on_ack_addr, redir_on_ack_pc;
  bit          redir_on_pend_en;
  logic [31:0] redir_on_pend_addr, redir_on_pend_pc;

  // Observations for the literal checks.
  logic [31:0] taken_q[$];
  logic [31:0] start_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_pc.delete();
    q_word.delete();
    taken_q.delete();
    start_q.delete();
    m_fpc         = 32'h0;
    pending       = 0;
    stale         = 0;
    remaining     = 0;
    pend_addr     = 32'h0;
    prev_req      = 0;
    prev_ack      = 0;
    prev_acc      = 0;
    prev_redirect = 0;
    prev_count    = 0;
    force_redir      = 0;
    redir_on_ack_en  = 0;
    redir_on_pend_en = 0;
  endtask

  task automatic idle_inputs();
    instr_take  = 0;
    redirect    = 0;
    redirect_pc = 32'h0;
    imem_ack    = 0;
    imem_rdata  = 32'h0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    check("rst_req",   32'(imem_req), 32'h0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc",    instr_pc, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // One cycle: compare at the negedge, play memory, drive core-side inputs, advance the model.
  task automatic step();
    bit          ack_now, acc, do_take, do_red, exp_req;
    logic [31:0] rpc;
    int          cnt0;
    @(negedge clk);
    imem_ack   = 0;
    imem_rdata = $urandom;
    cnt0       = q_pc.size();
    check("instr_valid", 32'(instr_valid), 32'(cnt0 != 0));
    if (cnt0 != 0) begin
      check("instr_pc", instr_pc, q_pc[0]);
      check("instr",    instr,    q_word[0]);
    end else begin
      check("instr_pc_idle", instr_pc, 32'h0);
      check("instr_idle",    instr,    32'h0);
    end

    ack_now = 0;
    if (pending) begin
      check("req_held",  32'(imem_req), 32'h1);
      check("addr_held", imem_addr, pend_addr);
      remaining--;
      if (remaining == 0) begin
        ack_now    = 1;
        pending    = 0;
        imem_ack   = 1;
        imem_rdata = mem_word(pend_addr);
      end
    end else begin
      if (prev_ack) exp_req = prev_acc && (cnt0 < DEPTH);
      else          exp_req = !prev_req && !prev_redirect && (prev_count < DEPTH);
      check("req", 32'(imem_req), 32'(exp_req));
      if (imem_req) begin
        check("req_addr", imem_addr, m_fpc);
        pending   = 1;
        stale     = 0;
        pend_addr = imem_addr;
        remaining = $urandom_range(lat_max, lat_min);
        start_q.push_back(imem_addr);
      end
    end

    do_take = ($urandom_range(99) < take_pct);
    do_red  = ($urandom_range(999) < redir_permil);
    rpc     = $urandom;
    if (force_redir) begin
      do_red      = 1;
      rpc         = force_pc;
      force_redir = 0;
    end
    if (redir_on_ack_en && ack_now && pend_addr == redir_on_ack_addr) begin
      do_red          = 1;
      rpc             = redir_on_ack_pc;
      redir_on_ack_en = 0;
    end
    if (redir_on_pend_en && pending && pend_addr == redir_on_pend_addr && remaining == 1) begin
      do_red           = 1;
      rpc              = redir_on_pend_pc;
      redir_on_pend_en = 0;
    end
    instr_take  = do_take;
    redirect    = do_red;
    redirect_pc = rpc;
    if (do_take && instr_valid && !do_red) taken_q.push_back(instr_pc);

    acc = ack_now && !stale && !do_red;
    if (do_red) begin
      q_pc.delete();
      q_word.delete();
      m_fpc = {rpc[31:2], 2'b00};
      if (pending) stale = 1;
    end else begin
      if (do_take && cnt0 != 0) begin
        void'(q_pc.pop_front());
        void'(q_word.pop_front());
      end
      if (acc) begin
        q_pc.push_back(pend_addr);
        q_word.push_back(mem_word(pend_addr));
      end
    end
    if (acc) m_fpc = pend_addr + 32'd4;
    prev_ack      = ack_now;
    prev_acc      = acc;
    prev_req      = imem_req;
    prev_redirect = do_red;
    prev_count    = cnt0;
  endtask

  task automatic knobs(input int lmin, input int lmax, input int tpct, input int rpm);
    lat_min      = lmin;
    lat_max      = lmax;
    take_pct     = tpct;
    redir_permil = rpm;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    knobs(1, 1, 0, 0);

    // 1: sequential fetch from 0 with immediate consumption.
    apply_reset();
    knobs(1, 1, 100, 0);
    repeat (20) step();
    for (int i = 0; i < 5; i++) begin
      check("t1_start", qat(start_q, i), 32'(i * 4));
      check("t1_taken", qat(taken_q, i), 32'(i * 4));
    end

    // 2: no consumption fills the buffer and stalls fetch; one take frees one slot.
    apply_reset();
    knobs(1, 1, 0, 0);
    repeat (14) step();
    check("t2_req_stalled", 32'(imem_req), 32'h0);
    check("t2_head_pc",     instr_pc, 32'h0);
    check("t2_starts",      32'(start_q.size()), 32'd4);
    take_pct = 100;
    step();
    take_pct = 0;
    start_q.delete();
    for (int i = 0; i < 10 && start_q.size() == 0; i++) step();
    check("t2_next_addr", qat(start_q, 0), 32'h10);

    // 3: redirect while a slow request to 0x8 is outstanding.
    apply_reset();
    knobs(3, 3, 100, 0);
    redir_on_pend_en   = 1;
    redir_on_pend_addr = 32'h8;
    redir_on_pend_pc   = 32'h40;
    for (int i = 0; i < 60 && taken_q.size() < 3; i++) step();
    check("t3_start2", qat(start_q, 2), 32'h8);
    check("t3_start3", qat(start_q, 3), 32'h40);
    check("t3_taken1", qat(taken_q, 1), 32'h4);
    check("t3_taken2", qat(taken_q, 2), 32'h40);

    // 4: redirect coinciding with the ack for 0xC; unaligned target.
    apply_reset();
    knobs(1, 1, 100, 0);
    redir_on_ack_en   = 1;
    redir_on_ack_addr = 32'hC;
    redir_on_ack_pc   = 32'h103;
    for (int i = 0; i < 40 && redir_on_ack_en; i++) step();
    check("t4_triggered", 32'(redir_on_ack_en), 32'h0);
    taken_q.delete();
    start_q.delete();
    step();
    check("t4_valid_after", 32'(instr_valid), 32'h0);
    for (int i = 0; i < 10 && taken_q.size() == 0; i++) step();
    check("t4_next_addr", qat(start_q, 0), 32'h100);
    check("t4_first_pc",  qat(taken_q, 0), 32'h100);

    // 5: reset asserted mid-request.
    apply_reset();
    knobs(3, 3, 100, 0);
    for (int i = 0; i < 20 && !pending; i++) step();
    check("t5_pending", 32'(pending), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("t5_req_drop",  32'(imem_req), 32'h0);
    check("t5_valid",     32'(instr_valid), 32'h0);
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 10 && start_q.size() == 0; i++) step();
    check("t5_restart", qat(start_q, 0), 32'h0);

    // 6: wrap-around from the top of the address space, with push and take overlapping.
    apply_reset();
    knobs(1, 1, 0, 0);
    force_redir = 1;
    force_pc    = 32'hFFFF_FFFC;
    step();
    repeat (10) step();
    take_pct = 100;
    taken_q.delete();
    repeat (16) step();
    check("t6_taken0", qat(taken_q, 0), 32'hFFFF_FFFC);
    check("t6_taken1", qat(taken_q, 1), 32'h0);
    check("t6_taken2", qat(taken_q, 2), 32'h4);
    check("t6_taken3", qat(taken_q, 3), 32'h8);

    // Random traffic: mixed latency, consumption rate and redirects.
    apply_reset();
    for (int seg = 0; seg < 8; seg++) begin
      knobs(1, $urandom_range(4, 1), (seg % 3 == 0) ? 30 : ((seg % 3 == 1) ? 70 : 100), 40);
      repeat (400) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
